// File: rtl/sanity_seq_pkg.sv
// Shared types for the sanity stream sequencer: FSM states and the per-job
// configuration record.
package sanity_seq_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [DEF_CNT_WIDTH-1:0]  len;
    logic [DEF_DATA_WIDTH-1:0] base;
    logic [DEF_DATA_WIDTH-1:0] stride;
  } seq_cfg_t;

endpackage

// File: rtl/sanity_seq_cnt.sv
// Loadable accumulator (base + n*stride) with a beat counter.
// Stride is captured on load so later input changes cannot disturb a job.
module sanity_seq_cnt
  import sanity_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] base_i,
  input  logic [DATA_WIDTH-1:0] stride_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CNT_WIDTH-1:0]  cnt_o
);

  logic [DATA_WIDTH-1:0] data_r;
  logic [DATA_WIDTH-1:0] stride_r;
  logic [CNT_WIDTH-1:0]  cnt_r;

  // accumulator, latched stride and beat counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_r   <= {DATA_WIDTH{1'b0}};
      stride_r <= {DATA_WIDTH{1'b0}};
      cnt_r    <= {CNT_WIDTH{1'b0}};
    end else if (clr_i) begin
      data_r   <= {DATA_WIDTH{1'b0}};
      cnt_r    <= {CNT_WIDTH{1'b0}};
    end else if (load_i) begin
      data_r   <= base_i;
      stride_r <= stride_i;
      cnt_r    <= {CNT_WIDTH{1'b0}};
    end else if (en_i) begin
      data_r   <= data_r + stride_r;
      cnt_r    <= cnt_r + CNT_WIDTH'(1);
    end
  end

  assign data_o = data_r;
  assign cnt_o  = cnt_r;

endmodule

// File: rtl/sanity_stream_seq.sv
// Sequencer emitting base, base+stride, ... as a valid/ready stream of len beats,
// with busy/done status. Every output comes straight from a register.
module sanity_stream_seq
  import sanity_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  len_i,
  input  logic [DATA_WIDTH-1:0] base_i,
  input  logic [DATA_WIDTH-1:0] stride_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  seq_state_e           state_r, state_s;
  logic                 valid_r, valid_s;
  logic                 last_r, last_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic                 load_s, en_s;
  logic [CNT_WIDTH-1:0] len_r;
  logic [CNT_WIDTH-1:0] cnt_s;

  sanity_seq_cnt #(
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clear_i),
    .load_i  (load_s),
    .en_i    (en_s),
    .base_i  (base_i),
    .stride_i(stride_i),
    .data_o  (data_o),
    .cnt_o   (cnt_s)
  );

  // next state and next registered outputs
  always_comb begin
    state_s = state_r;
    valid_s = valid_r;
    last_s  = last_r;
    done_s  = 1'b0;
    load_s  = 1'b0;
    en_s    = 1'b0;
    if (clear_i) begin
      state_s = ST_IDLE;
      valid_s = 1'b0;
      last_s  = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            load_s = 1'b1;
            if (len_i != {CNT_WIDTH{1'b0}}) begin
              state_s = ST_RUN;
              valid_s = 1'b1;
              last_s  = (len_i == CNT_WIDTH'(1));
            end else begin
              state_s = ST_DONE;
              done_s  = 1'b1;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (valid_r && ready_i) begin
            en_s = 1'b1;
            if (last_r) begin
              state_s = ST_DONE;
              valid_s = 1'b0;
              last_s  = 1'b0;
              done_s  = 1'b1;
            end else begin
              // last flag is precomputed for the beat being advanced to
              last_s = ((cnt_s + CNT_WIDTH'(1)) == (len_r - CNT_WIDTH'(1)));
            end
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_DONE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
          valid_s = 1'b0;
          last_s  = 1'b0;
        end
      endcase
    end
    busy_s = (state_s != ST_IDLE);
  end

  // state and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      valid_r <= valid_s;
      last_r  <= last_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // job length captured at start
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_r <= {CNT_WIDTH{1'b0}};
    end else if (load_s) begin
      len_r <= len_i;
    end
  end

  assign valid_o = valid_r;
  assign last_o  = last_r;
  assign busy_o  = busy_r;
  assign done_o  = done_r;

endmodule
